shift_target_arbiter: RTL and testbench

- Shares one shift-left-by-SHIFT-plus-add unit between two requesters: branch unit (req0) and jump unit (req1).
- Computes target = (operand << SHIFT) + base, mod 2^32.
- Round-robin arbitration, valid/ready handshakes, one registered output stage with a hold state for back-pressure.
- Sits between decode-stage target requesters and the PC-select logic.

---
 rtl/shift_target_arbiter_pkg.sv | 18 +
 rtl/shift_target_arbiter_if.sv | 38 +++
 rtl/shift_target_arbiter_rr.sv | 38 +++
 rtl/shift_target_arbiter.sv | 93 +++++++++
 tb/tb_shift_target_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_target_arbiter_pkg.sv
// Shared constants for the branch/jump target arbiter: requester ids,
// output-stage state encoding and the default shift amount.
package shift_target_arbiter_pkg;

    // Requester identifiers as they appear on the response id and last-grant.
    localparam logic ID_BRANCH = 1'b0;
    localparam logic ID_JUMP   = 1'b1;

    // Output-stage states, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_VALID = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    // Word-aligned targets: operands are instruction counts.
    localparam int SHIFT_AMT = 2;

endpackage

// File: rtl/shift_target_arbiter_if.sv
// Request/response bundle between the two target requesters, the shared
// shift+add unit and the PC-select consumer.
interface shift_target_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_operand;
    logic [WIDTH-1:0] req0_base;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_operand;
    logic [WIDTH-1:0] req1_base;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             last_grant;

    // Requesters and consumer side.
    modport master (
        output req0_valid, req0_operand, req0_base,
        output req1_valid, req1_operand, req1_base,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, last_grant
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_operand, req0_base,
        input  req1_valid, req1_operand, req1_base,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, last_grant
    );

endinterface

// File: rtl/shift_target_arbiter_rr.sv
// Two-way round-robin grant: when both requesters contend, the one that did
// not win last time is granted. Grants are suppressed while in reset or
// while the output stage cannot take a new result.
module rr_arbiter2
    import shift_target_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_free,
    output logic o_grant0,
    output logic o_grant1,
    output logic o_last_grant
);

    logic r_last_grant;
    logic w_enable;

    assign w_enable = i_free && !i_rst;

    // A lone requester always wins; contention goes to whoever lost last time.
    assign o_grant0 = w_enable && i_req0 && (!i_req1 || (r_last_grant == ID_JUMP));
    assign o_grant1 = w_enable && i_req1 && (!i_req0 || (r_last_grant == ID_BRANCH));

    assign o_last_grant = r_last_grant;

    // Remember the winner of each accepted request; reset favours req0 next.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: registers take <= so every flop samples pre-edge values.
        if (i_rst) begin
            r_last_grant <= ID_JUMP;
        end else if (o_grant0 || o_grant1) begin
            r_last_grant <= o_grant1;
        end
    end

endmodule

// File: rtl/shift_target_arbiter.sv
// Shares one (operand << SHIFT) + base unit between the branch and jump
// target requesters, with a single registered output stage that holds its
// result under back-pressure.
module shift_target_arbiter
    import shift_target_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = SHIFT_AMT
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    shift_target_arbiter_if.slave bus_if
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_data;
    logic             r_id;

    logic             w_rsp_valid;
    logic             w_free;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant_any;
    logic             w_last_grant;
    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_target;

    assign w_rsp_valid = (r_state != ST_IDLE);

    // A new result may be loaded when the register is empty or draining now.
    assign w_free = !w_rsp_valid || bus_if.rsp_ready;

    rr_arbiter2 u_arb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req0       (bus_if.req0_valid),
        .i_req1       (bus_if.req1_valid),
        .i_free       (w_free),
        .o_grant0     (w_grant0),
        .o_grant1     (w_grant1),
        .o_last_grant (w_last_grant)
    );

    assign w_grant_any = w_grant0 || w_grant1;

    // Shared datapath: high bits shifted out and the carry out are dropped.
    assign w_operand = w_grant1 ? bus_if.req1_operand : bus_if.req0_operand;
    assign w_base    = w_grant1 ? bus_if.req1_base    : bus_if.req0_base;
    assign w_target  = (w_operand << SHIFT) + w_base;

    // Output-stage sequencing: load on grant, hold while stalled, empty on drain.
    always_comb begin
        // NOTE: default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) w_state_next = ST_VALID;
            end
            ST_VALID, ST_HOLD: begin
                if (bus_if.rsp_ready) w_state_next = w_grant_any ? ST_VALID : ST_IDLE;
                else                  w_state_next = ST_HOLD;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register; reset discards any pending result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Result register loads only on an accepted request, otherwise holds.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_id   <= ID_BRANCH;
        end else if (w_grant_any) begin
            r_data <= w_target;
            r_id   <= w_grant1;
        end
    end

    assign bus_if.req0_ready = w_grant0;
    assign bus_if.req1_ready = w_grant1;
    assign bus_if.rsp_valid  = w_rsp_valid;
    assign bus_if.rsp_data   = r_data;
    assign bus_if.rsp_id     = r_id;
    assign bus_if.last_grant = w_last_grant;

endmodule

// File: tb/tb_shift_target_arbiter.sv
// Scenario-driven bench for shift_target_arbiter with a cycle-level reference
// model of the grant rules and output register.
module tb_shift_target_arbiter;
    import shift_target_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int SH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_target_arbiter_if #(.WIDTH(W)) bus();

    shift_target_arbiter #(.WIDTH(W), .SHIFT(SH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus_if (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: what the output register should hold.
    logic         m_valid;
    logic         m_id;
    logic         m_last;
    logic [W-1:0] m_data;
    logic         e_g0;
    logic         e_g1;

    // Target arithmetic as multiply-by-power-of-two, reduced mod 2^W.
    function automatic logic [W-1:0] ref_target(input logic [W-1:0] op, input logic [W-1:0] base);
        logic [63:0] prod;
        prod = 64'(op) * (64'd1 << SH) + 64'(base);
        return prod[W-1:0];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_last  = 1'b1;
        m_data  = '0;
        e_g0    = 1'b0;
        e_g1    = 1'b0;
    endtask

    // Expected grants from the current requests and model output state.
    task automatic model_predict();
        logic free;
        free = !m_valid || bus.rsp_ready;
        if (bus.req0_valid && bus.req1_valid) begin
            e_g0 = free && (m_last == 1'b1);
            e_g1 = free && (m_last == 1'b0);
        end else begin
            e_g0 = free && bus.req0_valid;
            e_g1 = free && bus.req1_valid;
        end
    endtask

    task automatic model_advance();
        if (e_g0 || e_g1) begin
            m_valid = 1'b1;
            m_id    = e_g1;
            m_last  = e_g1;
            m_data  = e_g1 ? ref_target(bus.req1_operand, bus.req1_base)
                           : ref_target(bus.req0_operand, bus.req0_base);
        end else if (bus.rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: predict, take the edge, advance the model, settle.
    task automatic tick();
        model_predict();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        bus.req0_valid = 1'b1; bus.req0_operand = 32'h1; bus.req0_base = 32'h2;
        bus.req1_valid = 1'b1; bus.req1_operand = 32'h3; bus.req1_base = 32'h4;
        bus.rsp_ready  = 1'b1;
        #2;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 1'b0 || bus.last_grant !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs got v=%b d=%h id=%b lg=%b want v=0 d=0 id=0 lg=1", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.last_grant);
        end
        total++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1; bus.req0_operand = 32'h0000_0004; bus.req0_base = 32'h0040_0008;
        bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0040_0018 || bus.rsp_id !== 1'b0 || bus.last_grant !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp got v=%b d=%h id=%b lg=%b want v=1 d=00400018 id=0 lg=0", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.last_grant);
        end
        tick();
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0040_0018) begin
            bad++;
            $display("FAIL single_drain got v=%b d=%h want v=0 d=00400018", bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_alternate();
        logic exp_id;
        pulse_reset();
        bus.req0_valid = 1'b1; bus.req0_operand = 32'h0000_0010; bus.req0_base = 32'h0000_1000;
        bus.req1_valid = 1'b1; bus.req1_operand = 32'h0000_0020; bus.req1_base = 32'h0200_0000;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            #1;
            total++;
            if (bus.req0_ready !== !exp_id || bus.req1_ready !== exp_id) begin
                bad++;
                $display("FAIL alt_grant[%0d] got r0=%b r1=%b want r0=%b r1=%b", i, bus.req0_ready, bus.req1_ready, !exp_id, exp_id);
            end
            tick();
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id || bus.last_grant !== exp_id ||
                bus.rsp_data !== (exp_id ? 32'h0200_0080 : 32'h0000_1040)) begin
                bad++;
                $display("FAIL alt_rsp[%0d] got v=%b id=%b lg=%b d=%h want v=1 id=%b lg=%b", i, bus.rsp_valid, bus.rsp_id, bus.last_grant, bus.rsp_data, exp_id, exp_id);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_operand = 32'hFFFF_FFFF; bus.req0_base = 32'h0000_0100;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_operand = 32'h0000_0005; bus.req1_base = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_ready[%0d] got r0=%b r1=%b want 0 0", i, bus.req0_ready, bus.req1_ready);
            end
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_00FC || bus.rsp_id !== 1'b0) begin
                bad++;
                $display("FAIL hold_rsp[%0d] got v=%b d=%h id=%b want v=1 d=000000fc id=0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready got r1=%b want 1", bus.req1_ready);
        end
        tick();
        bus.req1_valid = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_0024 || bus.rsp_id !== 1'b1) begin
            bad++;
            $display("FAIL release_rsp got v=%b d=%h id=%b want v=1 d=00000024 id=1", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_operand = 32'h4000_0001; bus.req0_base = 32'hFFFF_FFFC;
        tick();
        bus.req0_valid = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_0000 || bus.rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL wrap got v=%b d=%h id=%b want v=1 d=00000000 id=0", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
        end
        tick();
    endtask

    task automatic test_reset_hold();
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_operand = 32'h0000_0007; bus.req0_base = 32'h0000_0001;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.last_grant !== 1'b1) begin
            bad++;
            $display("FAIL async_reset got v=%b lg=%b want v=0 lg=1", bus.rsp_valid, bus.last_grant);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_operand = 32'h0000_0001; bus.req0_base = 32'h0000_0000;
        bus.req1_valid = 1'b1; bus.req1_operand = 32'h0000_0002; bus.req1_base = 32'h0000_0000;
        bus.rsp_ready  = 1'b1;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_grant got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h0000_0004) begin
            bad++;
            $display("FAIL post_reset_rsp got v=%b id=%b d=%h want v=1 id=0 d=00000004", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
    endtask

    task automatic test_withdraw();
        // Output currently holds a req0 result; stall it.
        bus.rsp_ready = 1'b0;
        tick();
        bus.req1_valid = 1'b1; bus.req1_operand = 32'h0000_0ABC; bus.req1_base = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (bus.req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL withdraw_ready[%0d] got r1=%b want 0", i, bus.req1_ready);
            end
            tick();
        end
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.last_grant !== 1'b0) begin
                bad++;
                $display("FAIL withdraw_rsp[%0d] got v=%b id=%b lg=%b want v=0 id=0 lg=0", i, bus.rsp_valid, bus.rsp_id, bus.last_grant);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
                bus.req0_valid = 1'b1; bus.req0_operand = $urandom; bus.req0_base = $urandom;
            end else if (bus.req0_valid && $urandom_range(0, 15) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
                bus.req1_valid = 1'b1; bus.req1_operand = $urandom; bus.req1_base = $urandom;
            end else if (bus.req1_valid && $urandom_range(0, 15) == 0) begin
                bus.req1_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            model_predict();
            #1;
            total++;
            if (bus.req0_ready !== e_g0 || bus.req1_ready !== e_g1) begin
                bad++;
                $display("FAIL rand_grant[%0d] got r0=%b r1=%b want r0=%b r1=%b", i, bus.req0_ready, bus.req1_ready, e_g0, e_g1);
            end
            tick();
            if (e_g0) bus.req0_valid = 1'b0;
            if (e_g1) bus.req1_valid = 1'b0;
            total++;
            if (bus.rsp_valid !== m_valid || bus.rsp_data !== m_data || bus.rsp_id !== m_id || bus.last_grant !== m_last) begin
                bad++;
                $display("FAIL rand_rsp[%0d] got v=%b d=%h id=%b lg=%b want v=%b d=%h id=%b lg=%b", i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.last_grant, m_valid, m_data, m_id, m_last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_wrap();
        test_reset_hold();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
